// File: rtl/wb_reg_file_pkg.sv
// Shared definitions for the writeback stage and register file: widths,
// index/word types, the zero-register constant and the MemToReg encoding.
package wb_reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Same encoding as the control unit drives into MEM/WB.
  typedef enum logic {
    MEMTOREG_ALU = 1'b0,
    MEMTOREG_MEM = 1'b1
  } memtoreg_e;

endpackage

// File: rtl/wb_reg_file_wb_mux.sv
// 2:1 writeback select (ALU result vs. load data); also instantiated by the
// forwarding unit so both sides agree on the writeback value.
module wb_mux
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              MemToReg_i,
  input  logic [DATA_W-1:0] ALU_Res_i,
  input  logic [DATA_W-1:0] Read_Data_i,
  output logic [DATA_W-1:0] WB_Data_o
);

  always_comb begin
    WB_Data_o = ALU_Res_i;
    if (memtoreg_e'(MemToReg_i) == MEMTOREG_MEM) begin
      WB_Data_o = Read_Data_i;
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// Writeback-side register file: commits the MEM/WB value, serves two async
// read ports and counts commits. Define WB_BYPASS_EN for write-before-read.
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [DATA_W-1:0] ALU_Res_i,
  input  logic [DATA_W-1:0] Read_Data_i,
  input  logic [ADDR_W-1:0] RdAddr_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] WB_Data_o,
  output logic [CNT_W-1:0]  WB_Count_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] wb_data;
  logic              wr_req;
  logic              commit;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .MemToReg_i (MemToReg_i),
    .ALU_Res_i  (ALU_Res_i),
    .Read_Data_i(Read_Data_i),
    .WB_Data_o  (wb_data)
  );

  assign WB_Data_o = wb_data;

  // Writes to r0 are architectural no-ops and are not counted.
  assign wr_req = RegWrite_i && (RdAddr_i != ZERO_IDX);
  assign commit = wr_req && !rst_i;

  always_comb begin
    count_d = count_q;
    if (commit) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[RdAddr_i] <= wb_data;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    RSdata_o = regs_q[RSaddr_i];
    RTdata_o = regs_q[RTaddr_i];
`ifdef WB_BYPASS_EN
    if (wr_req && (RSaddr_i == RdAddr_i)) begin
      RSdata_o = wb_data;
    end
    if (wr_req && (RTaddr_i == RdAddr_i)) begin
      RTdata_o = wb_data;
    end
`endif
    if (RSaddr_i == ZERO_IDX) begin
      RSdata_o = '0;
    end
    if (RTaddr_i == ZERO_IDX) begin
      RTdata_o = '0;
    end
  end

  assign WB_Count_o = count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Scoreboard bench for wb_reg_file: stimulus pushes expected outputs computed
// from an architectural array model; a negedge monitor pops and compares.
module tb_wb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, we, m2r;
  logic [DW-1:0] alu, rdd;
  logic [AW-1:0] rd, rsa, rta;
  logic [DW-1:0] rs_o, rt_o, wb_o;
  logic [CW-1:0] cnt_o;

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(we), .MemToReg_i(m2r),
    .ALU_Res_i(alu), .Read_Data_i(rdd), .RdAddr_i(rd),
    .RSaddr_i(rsa), .RTaddr_i(rta),
    .RSdata_o(rs_o), .RTdata_o(rt_o), .WB_Data_o(wb_o), .WB_Count_o(cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    bit            full;
    logic [DW-1:0] rs, rt, wb;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [32];
  int unsigned   mdl_cnt;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".wb"}, wb_o, e.wb);
        if (e.full) begin
          check({e.name, ".rs"}, rs_o, e.rs);
          check({e.name, ".rt"}, rt_o, e.rt);
          check({e.name, ".cnt"}, DW'(cnt_o), DW'(e.cnt));
        end
      end
    end
  end

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a, input logic [DW-1:0] wbv);
    if (a == 0) return '0;
    if (BYP && we && rd != 0 && a == rd) return wbv;
    return mdl[a];
  endfunction

  // Drive one cycle of inputs, queue the expectation, then advance the model.
  task automatic step(input string nm, input bit full, input logic r, input logic w,
                      input logic m, input logic [DW-1:0] a, input logic [DW-1:0] d,
                      input logic [AW-1:0] dst, input logic [AW-1:0] s, input logic [AW-1:0] t);
    exp_t e;
    rst = r; we = w; m2r = m; alu = a; rdd = d; rd = dst; rsa = s; rta = t;
    e.name = nm;
    e.full = full;
    e.wb   = m ? d : a;
    e.rs   = mdl_read(s, e.wb);
    e.rt   = mdl_read(t, e.wb);
    e.cnt  = CW'(mdl_cnt % (2 ** CW));
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdl_cnt = 0;
    end else if (w && dst != 0) begin
      mdl[dst] = e.wb;
      mdl_cnt++;
    end
    #1;
  endtask

  initial begin : stim
    int unsigned guard;
    rst = 1'b1; we = 1'b0; m2r = 1'b0; alu = '0; rdd = '0; rd = '0; rsa = '0; rta = '0;
    foreach (mdl[i]) mdl[i] = 'x;
    mdl_cnt = 0;
    @(posedge clk); #1;

    step("rst0", 1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd9, 5'd0, 5'd0);
    step("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 32'h3, 32'h4, 5'd0, 5'd1, 5'd2);
    for (int i = 0; i < 16; i++)
      step("rdall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, AW'(2*i), AW'(2*i+1));

    step("aluwr", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0BAD_0BAD, 5'd5, 5'd0, 5'd0);
    step("aluchk", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    step("r0wr", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
    step("r0chk", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
    step("r7old", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0777, 32'h0, 5'd7, 5'd0, 5'd0);
    step("byp", 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 32'h0, 5'd7, 5'd7, 5'd7);
    step("bypnext", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    step("rstpri", 1'b1, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd3);
    step("rstpchk", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
    step("rstclr", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 17; i++)
      step("wrap", 1'b1, 1'b0, 1'b1, i[0], 32'hA000_0000 + i, 32'hB000_0000 + i, AW'(i), 5'd0, 5'd0);
    step("wrapchk", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd1);

    for (int i = 0; i < 400; i++)
      step("rand", 1'b1, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), $urandom, $urandom, AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
